// File: rtl/spis_pkg.sv
// Shared definitions for the Avalon-MM SPI target: register offsets, status
// bit positions, FSM encodings and a saturating counter helper.
package spis_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned BIT_W  = 3;

    localparam logic [1:0] REG_STAT = 2'd0;
    localparam logic [1:0] REG_TX   = 2'd1;
    localparam logic [1:0] REG_CNT  = 2'd2;

    localparam int unsigned ST_IRQENA    = 15;
    localparam int unsigned ST_FRAME_END = 12;
    localparam int unsigned ST_OVERRUN   = 11;
    localparam int unsigned ST_TX_FULL   = 10;
    localparam int unsigned ST_RX_VALID  = 9;
    localparam int unsigned ST_NCS       = 8;

    typedef enum logic [2:0] {
        S_WAIT_HIGH = 3'b001,
        S_IDLE      = 3'b010,
        S_ACTIVE    = 3'b100
    } spis_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/spis_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with a history flop
// providing single-cycle rise/fall strobes.
module spis_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   hist_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_c  = level_o & ~hist_q;
    assign fall_c  = ~level_o & hist_q;

endmodule

// File: rtl/avalonif_spis.sv
// Avalon-MM SPI target (mode 3): oversampled host link, one TX holding byte,
// one RX byte with overrun detection, per-frame byte counter and level irq.
module avalonif_spis
    import spis_pkg::*;
#(
    parameter logic [7:0]  TX_FILL     = 8'hFF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic [1:0]        address,
    input  logic              read,
    output logic [DATA_W-1:0] readdata,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    output logic              irq,
    input  logic              SPIS_nCS,
    input  logic              SPIS_SCK,
    input  logic              SPIS_SDI,
    output logic              SPIS_SDO
);

    localparam int unsigned SETTLE_W = $clog2(SYNC_STAGES + 1);

    logic ncs_lvl, ncs_rise, ncs_fall;
    logic sck_lvl, sck_rise, sck_fall;
    logic sdi_lvl, sdi_rise, sdi_fall;

    spis_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk(clk), .reset_n(reset_n), .d_i(SPIS_nCS),
        .level_o(ncs_lvl), .rise_c(ncs_rise), .fall_c(ncs_fall)
    );
    spis_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .reset_n(reset_n), .d_i(SPIS_SCK),
        .level_o(sck_lvl), .rise_c(sck_rise), .fall_c(sck_fall)
    );
    spis_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
        .clk(clk), .reset_n(reset_n), .d_i(SPIS_SDI),
        .level_o(sdi_lvl), .rise_c(sdi_rise), .fall_c(sdi_fall)
    );

    spis_state_e         state_q, state_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic                irqena_q, irqena_d;
    logic                rx_valid_q, rx_valid_d;
    logic                overrun_q, overrun_d;
    logic                frame_end_q, frame_end_d;
    logic                tx_full_q, tx_full_d;
    logic [BYTE_W-1:0]   tx_buf_q, tx_buf_d;
    logic [BYTE_W-1:0]   rx_data_q, rx_data_d;
    logic [CNT_W-1:0]    bytecnt_q, bytecnt_d;
    logic [BIT_W-1:0]    bitcnt_q, bitcnt_d;
    logic                sdo_q, sdo_d;
    logic [BYTE_W-1:0]   shift_tx_q, shift_tx_d;
    logic [BYTE_W-1:0]   shift_rx_q, shift_rx_d;
    logic                irq_q, irq_d;
    logic [BYTE_W-1:0]   tx_src;
    logic [BYTE_W-1:0]   rx_byte;

    logic rd_stat, wr_stat, wr_tx;
    assign rd_stat = chipselect & read  & (address == REG_STAT);
    assign wr_stat = chipselect & write & (address == REG_STAT);
    assign wr_tx   = chipselect & write & (address == REG_TX);

    logic unused_ok;
    assign unused_ok = ^{writedata[31:16], writedata[14:13], writedata[10:8],
                         sck_lvl, sdi_rise, sdi_fall};

    // Bus side effects come first so same-cycle SPI events override them,
    // except the TX write, which must land after a same-cycle load.
    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        irqena_d    = irqena_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        frame_end_d = frame_end_q;
        tx_full_d   = tx_full_q;
        tx_buf_d    = tx_buf_q;
        rx_data_d   = rx_data_q;
        bytecnt_d   = bytecnt_q;
        bitcnt_d    = bitcnt_q;
        sdo_d       = sdo_q;
        shift_tx_d  = shift_tx_q;
        shift_rx_d  = shift_rx_q;
        tx_src      = tx_full_q ? tx_buf_q : TX_FILL;
        rx_byte     = {shift_rx_q[BYTE_W-2:0], sdi_lvl};

        if (rd_stat) begin
            rx_valid_d = 1'b0;
        end
        if (wr_stat) begin
            irqena_d = writedata[ST_IRQENA];
            if (writedata[ST_FRAME_END]) frame_end_d = 1'b0;
            if (writedata[ST_OVERRUN])   overrun_d   = 1'b0;
        end

        case (state_q)
            // Synced nCS reads 1 straight out of reset, so require it to stay
            // high until the synchronizer has refilled from the real pin.
            S_WAIT_HIGH: begin
                if (ncs_lvl) begin
                    if (settle_q == SETTLE_W'(SYNC_STAGES)) begin
                        state_d  = S_IDLE;
                        settle_d = '0;
                    end else begin
                        settle_d = settle_q + SETTLE_W'(1);
                    end
                end else begin
                    settle_d = '0;
                end
            end
            S_IDLE: begin
                if (ncs_fall) begin
                    state_d   = S_ACTIVE;
                    bitcnt_d  = '0;
                    bytecnt_d = '0;
                end
            end
            S_ACTIVE: begin
                if (ncs_rise) begin
                    state_d     = S_IDLE;
                    frame_end_d = 1'b1;
                    sdo_d       = 1'b1;
                    bitcnt_d    = '0;
                end else begin
                    if (sck_fall) begin
                        if (bitcnt_q == '0) begin
                            tx_full_d  = 1'b0;
                            sdo_d      = tx_src[BYTE_W-1];
                            shift_tx_d = {tx_src[BYTE_W-2:0], 1'b0};
                        end else begin
                            sdo_d      = shift_tx_q[BYTE_W-1];
                            shift_tx_d = {shift_tx_q[BYTE_W-2:0], 1'b0};
                        end
                    end
                    if (sck_rise) begin
                        shift_rx_d = rx_byte;
                        bitcnt_d   = bitcnt_q + BIT_W'(1);
                        if (bitcnt_q == BIT_W'(7)) begin
                            rx_data_d  = rx_byte;
                            bytecnt_d  = sat_inc(bytecnt_q);
                            if (rx_valid_q && !rd_stat) overrun_d = 1'b1;
                            rx_valid_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = S_WAIT_HIGH;
            end
        endcase

        if (wr_tx) begin
            tx_buf_d  = writedata[BYTE_W-1:0];
            tx_full_d = 1'b1;
        end

        irq_d = irqena_d & (rx_valid_d | overrun_d | frame_end_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_WAIT_HIGH;
            settle_q    <= '0;
            irqena_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_end_q <= 1'b0;
            tx_full_q   <= 1'b0;
            tx_buf_q    <= '0;
            rx_data_q   <= '0;
            bytecnt_q   <= '0;
            bitcnt_q    <= '0;
            sdo_q       <= 1'b1;
            shift_tx_q  <= '0;
            shift_rx_q  <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            irqena_q    <= irqena_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_end_q <= frame_end_d;
            tx_full_q   <= tx_full_d;
            tx_buf_q    <= tx_buf_d;
            rx_data_q   <= rx_data_d;
            bytecnt_q   <= bytecnt_d;
            bitcnt_q    <= bitcnt_d;
            sdo_q       <= sdo_d;
            shift_tx_q  <= shift_tx_d;
            shift_rx_q  <= shift_rx_d;
            irq_q       <= irq_d;
        end
    end

    // Zero-latency read mux
    always_comb begin
        readdata = '0;
        case (address)
            REG_STAT: begin
                readdata[ST_IRQENA]    = irqena_q;
                readdata[ST_FRAME_END] = frame_end_q;
                readdata[ST_OVERRUN]   = overrun_q;
                readdata[ST_TX_FULL]   = tx_full_q;
                readdata[ST_RX_VALID]  = rx_valid_q;
                readdata[ST_NCS]       = ncs_lvl;
                readdata[BYTE_W-1:0]   = rx_data_q;
            end
            REG_TX: begin
                readdata[ST_TX_FULL]   = tx_full_q;
                readdata[BYTE_W-1:0]   = tx_buf_q;
            end
            REG_CNT: begin
                readdata[CNT_W-1:0]    = bytecnt_q;
            end
            default: begin
                readdata = '0;
            end
        endcase
    end

    assign SPIS_SDO = sdo_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_avalonif_spis.sv
// Directed bench for avalonif_spis: a mode-3 SPI host model plus Avalon
// register accesses, with hand-computed expectations.
module tb_avalonif_spis;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        chipselect;
    logic [1:0]  address;
    logic        read;
    logic [31:0] readdata;
    logic        write;
    logic [31:0] writedata;
    logic        irq;
    logic        spis_ncs;
    logic        spis_sck;
    logic        spis_sdi;
    logic        spis_sdo;

    int n_tests = 0;
    int n_fail  = 0;

    avalonif_spis #(.TX_FILL(8'hFF), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
        .read(read), .readdata(readdata), .write(write), .writedata(writedata),
        .irq(irq), .SPIS_nCS(spis_ncs), .SPIS_SCK(spis_sck), .SPIS_SDI(spis_sdi),
        .SPIS_SDO(spis_sdo)
    );

    always #5 clk = ~clk;

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic av_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic av_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        #1 d = readdata;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
    endtask

    // n bits MSB first, half-period 4 clk; SDO captured as SCK rises
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        logic [7:0] sh;
        sh = tx;
        rx = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            spis_sck = 1'b0; spis_sdi = sh[7];
            sh = {sh[6:0], 1'b0};
            wait_clks(4);
            spis_sck = 1'b1;
            rx = {rx[6:0], spis_sdo};
            wait_clks(3);
        end
    endtask

    task automatic frame_begin();
        @(negedge clk);
        spis_ncs = 1'b0;
        wait_clks(4);
    endtask

    task automatic frame_finish();
        @(negedge clk);
        spis_ncs = 1'b1;
        wait_clks(8);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_n = 1'b0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        address = 2'd0; writedata = '0;
        spis_ncs = 1'b1; spis_sck = 1'b1; spis_sdi = 1'b1;
        wait_clks(3);
        reset_n = 1'b1;
        wait_clks(5);
        n_tests++;
        if (spis_sdo !== 1'b1) begin n_fail++; $display("FAIL reset_sdo got %b want 1", spis_sdo); end
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
        av_read(2'd0, d);
        n_tests++;
        if (d !== 32'h0000_0100) begin n_fail++; $display("FAIL reset_stat got %h want 00000100", d); end
        av_read(2'd1, d);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_tx got %h want 00000000", d); end
        av_read(2'd2, d);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_cnt got %h want 00000000", d); end
    endtask

    task automatic test_single_byte();
        logic [31:0] d;
        logic [7:0]  r;
        av_write(2'd1, 32'h0000_00A5);
        av_read(2'd1, d);
        n_tests++;
        if (d !== 32'h0000_04A5) begin n_fail++; $display("FAIL single_txreg got %h want 000004a5", d); end
        frame_begin();
        spi_bits(8'h3C, 8, r);
        frame_finish();
        n_tests++;
        if (r !== 8'hA5) begin n_fail++; $display("FAIL single_host_rx got %h want a5", r); end
        av_read(2'd0, d);
        n_tests++;
        if (d !== 32'h0000_133C) begin n_fail++; $display("FAIL single_stat got %h want 0000133c", d); end
        av_read(2'd2, d);
        n_tests++;
        if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL single_cnt got %h want 00000001", d); end
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL single_irq got %b want 0", irq); end
        av_write(2'd0, 32'h0000_1800);
        av_read(2'd0, d);
        n_tests++;
        if (d !== 32'h0000_013C) begin n_fail++; $display("FAIL single_clear got %h want 0000013c", d); end
    endtask

    task automatic test_multi_byte();
        logic [31:0] d;
        logic [7:0]  r0, r1, r2;
        frame_begin();
        spi_bits(8'h11, 8, r0);
        spi_bits(8'h22, 8, r1);
        spi_bits(8'h33, 8, r2);
        frame_finish();
        n_tests++;
        if ({r0, r1, r2} !== 24'hFFFFFF) begin n_fail++; $display("FAIL multi_host_rx got %h want ffffff", {r0, r1, r2}); end
        av_read(2'd0, d);
        n_tests++;
        if (d !== 32'h0000_1B33) begin n_fail++; $display("FAIL multi_stat got %h want 00001b33", d); end
        av_read(2'd2, d);
        n_tests++;
        if (d !== 32'h0000_0003) begin n_fail++; $display("FAIL multi_cnt got %h want 00000003", d); end
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL multi_irq_off got %b want 0", irq); end
        av_write(2'd0, 32'h0000_8000);
        n_tests++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL multi_irq_on got %b want 1", irq); end
        av_write(2'd0, 32'h0000_9800);
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL multi_irq_clr got %b want 0", irq); end
        av_read(2'd0, d);
        n_tests++;
        if (d !== 32'h0000_8133) begin n_fail++; $display("FAIL multi_stat_clr got %h want 00008133", d); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        logic [7:0]  r;
        frame_begin();
        spi_bits(8'hB7, 4, r);
        @(negedge clk);
        reset_n = 1'b0;
        wait_clks(3);
        reset_n = 1'b1;
        wait_clks(2);
        spi_bits(8'h70, 4, r);
        n_tests++;
        if (r !== 8'h0F) begin n_fail++; $display("FAIL midrst_sdo got %h want 0f", r); end
        frame_finish();
        av_read(2'd0, d);
        n_tests++;
        if (d !== 32'h0000_0100) begin n_fail++; $display("FAIL midrst_stat got %h want 00000100", d); end
        av_read(2'd2, d);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL midrst_cnt got %h want 00000000", d); end
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL midrst_irq got %b want 0", irq); end
        av_write(2'd1, 32'h0000_005A);
        frame_begin();
        spi_bits(8'hC3, 8, r);
        frame_finish();
        n_tests++;
        if (r !== 8'h5A) begin n_fail++; $display("FAIL midrst_next_rx got %h want 5a", r); end
        av_read(2'd0, d);
        n_tests++;
        if (d !== 32'h0000_13C3) begin n_fail++; $display("FAIL midrst_next_stat got %h want 000013c3", d); end
        av_write(2'd0, 32'h0000_1000);
    endtask

    task automatic test_simultaneous();
        logic [31:0] d, d_in;
        logic [7:0]  r0, r1;
        frame_begin();
        spi_bits(8'h81, 8, r0);
        spi_bits(8'h7E, 7, r1);
        @(negedge clk);
        spis_sck = 1'b0; spis_sdi = 1'b0;
        wait_clks(4);
        spis_sck = 1'b1;
        r1 = {r1[6:0], spis_sdo};
        wait_clks(2);
        chipselect = 1'b1; read = 1'b1; address = 2'd0;
        #1 d_in = readdata;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        wait_clks(4);
        n_tests++;
        if (d_in !== 32'h0000_0281) begin n_fail++; $display("FAIL simul_read_old got %h want 00000281", d_in); end
        @(negedge clk);
        spis_ncs = 1'b1;
        wait_clks(2);
        chipselect = 1'b1; write = 1'b1; address = 2'd0; writedata = 32'h0000_1000;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        wait_clks(6);
        n_tests++;
        if ({r0, r1} !== 16'hFFFF) begin n_fail++; $display("FAIL simul_host_rx got %h want ffff", {r0, r1}); end
        av_read(2'd0, d);
        n_tests++;
        if (d !== 32'h0000_137E) begin n_fail++; $display("FAIL simul_stat got %h want 0000137e", d); end
        av_write(2'd0, 32'h0000_1800);
    endtask

    task automatic test_tx_collision();
        logic [31:0] d;
        logic [7:0]  r0, r1, rt;
        frame_begin();
        @(negedge clk);
        spis_sck = 1'b0; spis_sdi = 1'b0;
        wait_clks(2);
        chipselect = 1'b1; write = 1'b1; address = 2'd1; writedata = 32'h0000_0096;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        wait_clks(1);
        spis_sck = 1'b1;
        r0 = {7'd0, spis_sdo};
        wait_clks(3);
        spi_bits(8'h00, 7, rt);
        r0 = {r0[0], rt[6:0]};
        n_tests++;
        if (r0 !== 8'hFF) begin n_fail++; $display("FAIL coll_first_rx got %h want ff", r0); end
        av_read(2'd1, d);
        n_tests++;
        if (d !== 32'h0000_0496) begin n_fail++; $display("FAIL coll_txreg_full got %h want 00000496", d); end
        spi_bits(8'h42, 8, r1);
        frame_finish();
        n_tests++;
        if (r1 !== 8'h96) begin n_fail++; $display("FAIL coll_second_rx got %h want 96", r1); end
        av_read(2'd1, d);
        n_tests++;
        if (d !== 32'h0000_0096) begin n_fail++; $display("FAIL coll_txreg_empty got %h want 00000096", d); end
        av_read(2'd0, d);
        n_tests++;
        if (d !== 32'h0000_1B42) begin n_fail++; $display("FAIL coll_stat got %h want 00001b42", d); end
        av_read(2'd2, d);
        n_tests++;
        if (d !== 32'h0000_0002) begin n_fail++; $display("FAIL coll_cnt got %h want 00000002", d); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_multi_byte();
        test_reset_mid_frame();
        test_simultaneous();
        test_tx_collision();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
